victim_buffer_fa: RTL and testbench
===================================

VICTIM_BUFFER_FA -- requirements
Module: victim_buffer_fa

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, number of fully-associative entries (power of 2, >=2).
REQ-002 SHALL have parameter S_OFFSET, default 5, byte-offset bits per line.
REQ-003 SHALL have parameter S_LINE, default 256, line width in bits; S_LADDR = 32-S_OFFSET is the line-address width.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ins_valid/ins_ready (in/out, 1), ins_laddr (in, S_LADDR), ins_data (in, S_LINE), ins_dirty (in, 1): eviction from main cache.
REQ-007 SHALL have lk_valid (in, 1), lk_laddr (in, S_LADDR), lk_hit (out, 1), lk_data (out, S_LINE), lk_dirty (out, 1): swap lookup.
REQ-008 SHALL have wb_valid (out, 1), wb_ready (in, 1), wb_laddr (out, S_LADDR), wb_data (out, S_LINE): dirty writeback to memory.

Function
REQ-009 SHALL hold per entry: valid, dirty, laddr, data, age (log2(ENTRIES) bits).
REQ-010 SHALL compute lk_hit combinationally = lk_valid AND some valid entry's laddr equals lk_laddr; lk_data/lk_dirty from that entry, zero on miss.
REQ-011 SHALL, on a cycle with lk_hit=1, invalidate the hitting entry at the next edge (swap semantics: line moves to main cache).
REQ-012 SHALL implement FSM IDLE, WB (plus FLUSH per REQ-024); ins_ready=1 only in IDLE.
REQ-013 SHALL accept insert on ins_valid AND ins_ready; target slot: hitting slot if same-cycle lk_hit, else lowest-index invalid entry, else oldest valid entry (max age; ties to lowest index).
REQ-014 SHALL, if ins_laddr matches a valid entry not being swapped out, overwrite that entry's data with dirty = old dirty OR ins_dirty, no eviction.
REQ-015 SHALL, when target is an occupied dirty entry, latch it into a writeback register, write the new line into the slot in the same edge, and enter WB.
REQ-016 SHALL, when target is an occupied clean entry, overwrite silently and stay in IDLE.
REQ-017 SHALL in WB drive wb_valid=1 with stable wb_laddr/wb_data until wb_valid AND wb_ready, then return to IDLE next edge; wb_valid=0 outside WB/FLUSH writeback.
REQ-018 SHALL set the written entry's age to 0 and increment every other valid entry whose age was below the target's old age (new entries treat old age as ENTRIES-1); ages saturate, never wrap.
REQ-019 SHALL, on invalidation by lookup, leave remaining ages unchanged; lookups SHALL be serviced in every state including WB.
REQ-020 SHALL give a lookup matching the writeback register lk_hit=0 (line owned by memory path); lk_valid with no match has no side effect.

Reset
REQ-021 SHALL on rst asynchronously clear all valid, dirty, age bits, FSM to IDLE, wb_valid=0, ins_ready=1, lk_hit=0; data/laddr storage need not reset.
REQ-022 SHALL on rst asserted mid-WB drop the pending writeback without handshake; deassertion returns to IDLE.

Configuration
REQ-023 SHALL compile flush support only when macro VICTIM_BUF_FLUSH_EN is defined.
REQ-024 SHALL with VICTIM_BUF_FLUSH_EN add flush_req (in, 1) and flush_done (out, 1): in IDLE flush_req enters FLUSH, writes back every valid dirty entry in ascending index via wb handshake, invalidates all entries, pulses flush_done one cycle, returns IDLE; ins_ready=0 and lk_hit=0 during FLUSH.
REQ-025 SHALL without VICTIM_BUF_FLUSH_EN omit flush_req/flush_done ports and the FLUSH state entirely.

Verification (ENTRIES=4)
REQ-026 SHALL test: reset, insert laddrs 0x10,0x11,0x12,0x13 clean -> slots 0..3 valid, ages 3,2,1,0, no wb_valid.
REQ-027 SHALL test: full buffer, 0x10 dirty oldest, insert 0x20 -> wb_valid with wb_laddr=0x10, ins_ready=0 until wb_ready; 0x20 in slot 0 age 0.
REQ-028 SHALL test: lk_laddr=0x12 with ins 0x30 same cycle -> lk_hit=1, lk_data=0x12's line, 0x30 written into 0x12's slot, no writeback.
REQ-029 SHALL test: during WB hold wb_ready=0 for 5 cycles -> wb outputs stable, lookup of 0x11 still hits.
REQ-030 SHALL test: assert rst during WB -> wb_valid=0 immediately, all lk_hit=0, ins_ready=1 after deassertion.
REQ-031 SHALL test (flush build): two dirty, two clean entries, flush_req -> exactly two wb handshakes in index order, then flush_done pulse, all entries invalid.

Source files
------------

// File: rtl/victim_buffer_fa_if.sv
//------------------------------------------------------------------------------
// Module     : victim_buffer_fa_if
// Description: Bus bundle for the fully-associative victim buffer.
//              Groups three channels:
//                ins_* : eviction from the main cache into the buffer
//                lk_*  : combinational swap lookup
//                wb_*  : dirty-line writeback to memory
//              With VICTIM_BUF_FLUSH_EN defined, flush_req/flush_done are
//              added.
//              Modports:
//                slave  - the victim buffer
//                master - the cache / memory side driving it
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface victim_buffer_fa_if #(
    parameter int S_LADDR = 27,
    parameter int S_LINE  = 256
);
    logic               ins_valid;
    logic               ins_ready;
    logic [S_LADDR-1:0] ins_laddr;
    logic [S_LINE-1:0]  ins_data;
    logic               ins_dirty;

    logic               lk_valid;
    logic [S_LADDR-1:0] lk_laddr;
    logic               lk_hit;
    logic [S_LINE-1:0]  lk_data;
    logic               lk_dirty;

    logic               wb_valid;
    logic               wb_ready;
    logic [S_LADDR-1:0] wb_laddr;
    logic [S_LINE-1:0]  wb_data;

`ifdef VICTIM_BUF_FLUSH_EN
    logic               flush_req;
    logic               flush_done;
`endif

    modport slave (
        input  ins_valid, ins_laddr, ins_data, ins_dirty,
        output ins_ready,
        input  lk_valid, lk_laddr,
        output lk_hit, lk_data, lk_dirty,
        output wb_valid, wb_laddr, wb_data,
        input  wb_ready
`ifdef VICTIM_BUF_FLUSH_EN
        ,
        input  flush_req,
        output flush_done
`endif
    );

    modport master (
        output ins_valid, ins_laddr, ins_data, ins_dirty,
        input  ins_ready,
        output lk_valid, lk_laddr,
        input  lk_hit, lk_data, lk_dirty,
        input  wb_valid, wb_laddr, wb_data,
        output wb_ready
`ifdef VICTIM_BUF_FLUSH_EN
        ,
        output flush_req,
        input  flush_done
`endif
    );
endinterface

`default_nettype wire

// File: rtl/victim_buffer_fa.sv
//------------------------------------------------------------------------------
// Module     : victim_buffer_fa
// Description: Fully-associative victim buffer with age-based replacement.
//              Lines evicted by the main cache are inserted here; a lookup
//              hit hands the line back (swap) and frees the entry.  Replacing
//              a dirty line parks it in a writeback register and blocks
//              further inserts until memory accepts it.
//              Optional flush (macro VICTIM_BUF_FLUSH_EN): writes back every
//              dirty entry in index order, then invalidates the buffer.
// Ports      : clk  - clock, rising edge
//              rst  - asynchronous active-high reset
//              bus  - victim_buffer_fa_if.slave (ins_*, lk_*, wb_*, and
//                     flush_req/flush_done when flush is compiled in)
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module victim_buffer_fa #(
    parameter int ENTRIES  = 4,
    parameter int S_OFFSET = 5,
    parameter int S_LINE   = 256
) (
    input  wire logic         clk,
    input  wire logic         rst,
    victim_buffer_fa_if.slave bus
);
    localparam int              S_LADDR = 32 - S_OFFSET;
    localparam int              IW      = $clog2(ENTRIES);
    localparam logic [IW-1:0]   AGE_MAX = IW'(ENTRIES - 1);

`ifdef VICTIM_BUF_FLUSH_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WB = 2'd1, ST_FLUSH = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WB = 2'd1} state_t;
`endif

    state_t state_q, state_d;

    // Entry storage: control bits are reset, payload is not.
    logic               valid_q [ENTRIES];
    logic               dirty_q [ENTRIES];
    logic [IW-1:0]      age_q   [ENTRIES];
    logic [S_LADDR-1:0] laddr_q [ENTRIES];
    logic [S_LINE-1:0]  data_q  [ENTRIES];

    logic [S_LADDR-1:0] wb_laddr_q;
    logic [S_LINE-1:0]  wb_data_q;

    logic               w_hit_any,   w_lk_hit;
    logic [IW-1:0]      w_hit_idx;
    logic               w_match_any;
    logic [IW-1:0]      w_match_idx;
    logic               w_free_any;
    logic [IW-1:0]      w_free_idx;
    logic [IW-1:0]      w_old_idx,   w_old_age;
    logic [IW-1:0]      w_tgt_idx,   w_tgt_old_age;
    logic               w_tgt_merge, w_evict_dirty;
    logic               w_ins_fire,  w_wb_shadow;
    logic               w_flushing,  w_flush_start, w_flush_last;

    //--------------------------------------------------------------------------
    // Flush sequencer (optional)
    //--------------------------------------------------------------------------
`ifdef VICTIM_BUF_FLUSH_EN
    logic [IW-1:0] flush_idx_q;
    logic          flush_done_q;
    logic          w_flush_need, w_flush_adv;

    assign w_flushing    = (state_q == ST_FLUSH);
    assign w_flush_start = (state_q == ST_IDLE) && bus.flush_req;
    assign w_flush_need  = valid_q[flush_idx_q] && dirty_q[flush_idx_q];
    // Clean or empty slots are skipped in one cycle; dirty ones wait for memory.
    assign w_flush_adv   = w_flushing && (!w_flush_need || bus.wb_ready);
    assign w_flush_last  = w_flush_adv && (flush_idx_q == AGE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_idx_q  <= '0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= w_flush_last;
            if (w_flush_adv)
                flush_idx_q <= flush_idx_q + 1'b1;   // wraps to 0 after last slot
        end
    end

    assign bus.flush_done = flush_done_q;
    assign bus.wb_valid   = (state_q == ST_WB) || (w_flushing && w_flush_need);
    assign bus.wb_laddr   = w_flushing ? laddr_q[flush_idx_q] : wb_laddr_q;
    assign bus.wb_data    = w_flushing ? data_q[flush_idx_q]  : wb_data_q;
`else
    assign w_flushing    = 1'b0;
    assign w_flush_start = 1'b0;
    assign w_flush_last  = 1'b0;
    assign bus.wb_valid  = (state_q == ST_WB);
    assign bus.wb_laddr  = wb_laddr_q;
    assign bus.wb_data   = wb_data_q;
`endif

    //--------------------------------------------------------------------------
    // Lookup, insert-target selection
    //--------------------------------------------------------------------------
    // The parked writeback line is owned by the memory path: never report it.
    assign w_wb_shadow = (state_q == ST_WB) && (bus.lk_laddr == wb_laddr_q);
    assign w_ins_fire  = bus.ins_valid && bus.ins_ready;

    always_comb begin
        w_hit_any     = 1'b0;
        w_hit_idx     = '0;
        w_match_any   = 1'b0;
        w_match_idx   = '0;
        w_free_any    = 1'b0;
        w_free_idx    = '0;
        w_old_idx     = '0;
        w_old_age     = '0;
        w_lk_hit      = 1'b0;
        w_tgt_idx     = '0;
        w_tgt_old_age = AGE_MAX;
        w_tgt_merge   = 1'b0;
        w_evict_dirty = 1'b0;

        for (int i = 0; i < ENTRIES; i++) begin
            if (!w_hit_any && valid_q[i] && (laddr_q[i] == bus.lk_laddr)) begin
                w_hit_any = 1'b1;
                w_hit_idx = IW'(i);
            end
            if (!w_free_any && !valid_q[i]) begin
                w_free_any = 1'b1;
                w_free_idx = IW'(i);
            end
            // Strict compare keeps the lowest index among equal oldest ages.
            if (valid_q[i] && (age_q[i] > w_old_age)) begin
                w_old_age = age_q[i];
                w_old_idx = IW'(i);
            end
        end

        w_lk_hit = bus.lk_valid && w_hit_any && !w_flushing && !w_wb_shadow;

        // An entry leaving via swap this cycle cannot absorb the insert.
        for (int i = 0; i < ENTRIES; i++) begin
            if (!w_match_any && valid_q[i] && (laddr_q[i] == bus.ins_laddr) &&
                !(w_lk_hit && (w_hit_idx == IW'(i)))) begin
                w_match_any = 1'b1;
                w_match_idx = IW'(i);
            end
        end

        // Merging into an existing copy wins so a line never lives twice.
        if (w_match_any) begin
            w_tgt_idx     = w_match_idx;
            w_tgt_old_age = age_q[w_match_idx];
            w_tgt_merge   = 1'b1;
        end else if (w_lk_hit) begin
            w_tgt_idx     = w_hit_idx;
        end else if (w_free_any) begin
            w_tgt_idx     = w_free_idx;
        end else begin
            w_tgt_idx     = w_old_idx;
            w_tgt_old_age = w_old_age;
            w_evict_dirty = dirty_q[w_old_idx];
        end
    end

    assign bus.lk_hit    = w_lk_hit;
    assign bus.lk_data   = w_lk_hit ? data_q[w_hit_idx] : '0;
    assign bus.lk_dirty  = w_lk_hit && dirty_q[w_hit_idx];
    assign bus.ins_ready = (state_q == ST_IDLE) && !w_flush_start;

    //--------------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_flush_start)
                    state_d = state_t'(2'd2);
                else if (w_ins_fire && w_evict_dirty)
                    state_d = ST_WB;
            end
            ST_WB: begin
                if (bus.wb_ready)
                    state_d = ST_IDLE;
            end
`ifdef VICTIM_BUF_FLUSH_EN
            ST_FLUSH: begin
                if (w_flush_last)
                    state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Entry control bits and ages
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
                age_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (w_flush_last) begin
                    valid_q[i] <= 1'b0;
                    dirty_q[i] <= 1'b0;
                    age_q[i]   <= '0;
                end else if (w_ins_fire && (w_tgt_idx == IW'(i))) begin
                    valid_q[i] <= 1'b1;
                    dirty_q[i] <= w_tgt_merge ? (dirty_q[i] | bus.ins_dirty) : bus.ins_dirty;
                    age_q[i]   <= '0;
                end else if (w_lk_hit && (w_hit_idx == IW'(i))) begin
                    valid_q[i] <= 1'b0;
                    dirty_q[i] <= 1'b0;
                end else if (w_ins_fire && valid_q[i] && (age_q[i] < w_tgt_old_age) &&
                             (age_q[i] != AGE_MAX)) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    // Payload storage and the parked writeback line carry no reset.
    always_ff @(posedge clk) begin
        if (w_ins_fire) begin
            if (w_evict_dirty) begin
                wb_laddr_q <= laddr_q[w_tgt_idx];
                wb_data_q  <= data_q[w_tgt_idx];
            end
            laddr_q[w_tgt_idx] <= bus.ins_laddr;
            data_q[w_tgt_idx]  <= bus.ins_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_victim_buffer_fa.sv
//------------------------------------------------------------------------------
// Module     : tb_victim_buffer_fa
// Description: Scoreboard bench for victim_buffer_fa (ENTRIES=4).  A stimulus
//              process drives one cycle at a time, predicts the response with
//              a behavioural model of the buffer and queues the expectation;
//              a monitor process pops and compares on the falling edge.
//              Flush scenario is compiled only with VICTIM_BUF_FLUSH_EN.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_victim_buffer_fa;
    localparam int ENTRIES  = 4;
    localparam int S_OFFSET = 5;
    localparam int S_LINE   = 256;
    localparam int S_LADDR  = 32 - S_OFFSET;

    typedef logic [S_LADDR-1:0] laddr_t;
    typedef logic [S_LINE-1:0]  line_t;

    typedef struct {
        bit    ins_ready;
        bit    lk_valid;
        bit    lk_hit;
        line_t lk_data;
        bit    lk_dirty;
        bit    wb_valid;
        bit    wb_ready;
    } cyc_exp_t;

    typedef struct {
        laddr_t laddr;
        line_t  data;
    } wb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    victim_buffer_fa_if #(.S_LADDR(S_LADDR), .S_LINE(S_LINE)) bus ();

    victim_buffer_fa #(.ENTRIES(ENTRIES), .S_OFFSET(S_OFFSET), .S_LINE(S_LINE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cyc_exp_t cq[$];
    wb_t      wq[$];
    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a set of lines, each with a recency rank.
    bit     m_valid [ENTRIES];
    bit     m_dirty [ENTRIES];
    laddr_t m_laddr [ENTRIES];
    line_t  m_data  [ENTRIES];
    int     m_age   [ENTRIES];
    bit     m_wbpend;

    task automatic chk(input string name, input logic [S_LINE-1:0] act, input logic [S_LINE-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic line_t rnd_line();
        line_t l;
        for (int k = 0; k < S_LINE / 32; k++) l[k*32 +: 32] = $urandom();
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_dirty[i] = 0; m_age[i] = 0;
        end
        m_wbpend = 0;
        wq.delete();
    endtask

    // One clock: drive at posedge+1, predict, advance model past the edge.
    task automatic cycle(input bit iv, input laddr_t ila, input line_t idat, input bit idirty,
                         input bit lv, input laddr_t lla, input bit wr);
        cyc_exp_t e;
        int hit, tgt, old_age, best;
        bit merge, fire;
        bus.ins_valid = iv; bus.ins_laddr = ila; bus.ins_data = idat; bus.ins_dirty = idirty;
        bus.lk_valid  = lv; bus.lk_laddr  = lla; bus.wb_ready = wr;

        hit = -1;
        if (lv)
            for (int i = 0; i < ENTRIES; i++)
                if (m_valid[i] && m_laddr[i] == lla) hit = i;
        e.ins_ready = !m_wbpend;
        e.lk_valid  = lv;
        e.lk_hit    = (hit >= 0);
        e.lk_data   = (hit >= 0) ? m_data[hit] : '0;
        e.lk_dirty  = (hit >= 0) && m_dirty[hit];
        e.wb_valid  = m_wbpend;
        e.wb_ready  = wr;
        cq.push_back(e);

        fire = iv && !m_wbpend;
        if (m_wbpend && wr) m_wbpend = 0;
        if (hit >= 0) begin m_valid[hit] = 0; m_dirty[hit] = 0; end
        if (fire) begin
            tgt = -1; merge = 0; old_age = ENTRIES - 1;
            for (int i = 0; i < ENTRIES; i++)
                if (m_valid[i] && m_laddr[i] == ila) tgt = i;
            if (tgt >= 0) begin
                merge = 1; old_age = m_age[tgt];
            end else if (hit >= 0) begin
                tgt = hit;
            end else begin
                for (int i = ENTRIES - 1; i >= 0; i--) if (!m_valid[i]) tgt = i;
                if (tgt < 0) begin
                    best = 0;
                    for (int i = 1; i < ENTRIES; i++) if (m_age[i] > m_age[best]) best = i;
                    tgt = best; old_age = m_age[best];
                    if (m_dirty[best]) begin
                        wq.push_back('{laddr: m_laddr[best], data: m_data[best]});
                        m_wbpend = 1;
                    end
                end
            end
            for (int i = 0; i < ENTRIES; i++)
                if (i != tgt && m_valid[i] && m_age[i] < old_age && m_age[i] < ENTRIES - 1)
                    m_age[i]++;
            m_dirty[tgt] = merge ? (m_dirty[tgt] | idirty) : idirty;
            m_valid[tgt] = 1; m_laddr[tgt] = ila; m_data[tgt] = idat; m_age[tgt] = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit wr);
        cycle(0, '0, '0, 0, 0, '0, wr);
    endtask

    task automatic ins(input laddr_t a, input bit d, input bit wr);
        cycle(1, a, rnd_line(), d, 0, '0, wr);
    endtask

    task automatic check_state();
        for (int i = 0; i < ENTRIES; i++) begin
            chk($sformatf("valid[%0d]", i), dut.valid_q[i], m_valid[i]);
            if (m_valid[i]) begin
                chk($sformatf("age[%0d]", i), dut.age_q[i], m_age[i]);
                chk($sformatf("laddr[%0d]", i), dut.laddr_q[i], m_laddr[i]);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ins_valid = 0; bus.lk_valid = 0; bus.wb_ready = 0;
`ifdef VICTIM_BUF_FLUSH_EN
        bus.flush_req = 0;
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: compares the queued expectation on every falling edge.
    initial begin
        cyc_exp_t e;
        forever begin
            @(negedge clk);
            if (cq.size() > 0) begin
                e = cq.pop_front();
                chk("ins_ready", bus.ins_ready, e.ins_ready);
                chk("wb_valid", bus.wb_valid, e.wb_valid);
                if (e.lk_valid) begin
                    chk("lk_hit", bus.lk_hit, e.lk_hit);
                    chk("lk_data", bus.lk_data, e.lk_data);
                    chk("lk_dirty", bus.lk_dirty, e.lk_dirty);
                end
                if (e.wb_valid && bus.wb_valid) begin
                    if (wq.size() == 0) begin
                        n_chk++;
                        $display("FAIL wb_unexpected: got wb_laddr %0h expected none", bus.wb_laddr);
                    end else begin
                        chk("wb_laddr", bus.wb_laddr, wq[0].laddr);
                        chk("wb_data", bus.wb_data, wq[0].data);
                        if (e.wb_ready) void'(wq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.ins_valid = 0; bus.ins_laddr = '0; bus.ins_data = '0; bus.ins_dirty = 0;
        bus.lk_valid = 0; bus.lk_laddr = '0; bus.wb_ready = 0;
`ifdef VICTIM_BUF_FLUSH_EN
        bus.flush_req = 0;
`endif
        @(posedge clk); #1;

        // Reset state and in-order fill.
        do_reset();
        cycle(0, '0, '0, 0, 1, 27'h10, 0);
        for (int a = 'h10; a <= 'h13; a++) ins(laddr_t'(a), 0, 1);
        idle(1);
        for (int i = 0; i < ENTRIES; i++) begin
            chk($sformatf("fill_valid[%0d]", i), dut.valid_q[i], 1);
            chk($sformatf("fill_age[%0d]", i), dut.age_q[i], 3 - i);
        end
        check_state();

        // Dirty eviction, stalled writeback, lookup during WB, swap insert.
        do_reset();
        ins(27'h10, 1, 1);
        for (int a = 'h11; a <= 'h13; a++) ins(laddr_t'(a), 0, 1);
        ins(27'h20, 0, 0);
        for (int k = 0; k < 5; k++)
            cycle(1, 27'h55, rnd_line(), 0, (k == 2), 27'h11, 0);
        idle(1);
        idle(1);
        chk("evict_slot0_laddr", dut.laddr_q[0], 27'h20);
        chk("evict_slot0_age", dut.age_q[0], 0);
        check_state();
        cycle(1, 27'h30, rnd_line(), 0, 1, 27'h12, 1);
        idle(1);
        chk("swap_slot2_laddr", dut.laddr_q[2], 27'h30);
        check_state();

        // Reset asserted in the middle of a writeback.
        do_reset();
        ins(27'h10, 1, 1);
        for (int a = 'h11; a <= 'h13; a++) ins(laddr_t'(a), 0, 1);
        ins(27'h20, 0, 0);
        #2 rst = 1'b1;
        #1 chk("rst_wb_valid", bus.wb_valid, 0);
        bus.lk_valid = 1; bus.lk_laddr = 27'h12;
        #1 chk("rst_lk_hit", bus.lk_hit, 0);
        chk("rst_ins_ready", bus.ins_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        cycle(0, '0, '0, 0, 1, 27'h12, 0);
        check_state();

        // Randomised traffic over a small address pool.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 9) < 6), laddr_t'(27'h40 + $urandom_range(0, 7)), rnd_line(),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4),
                  laddr_t'(27'h40 + $urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if (n % 25 == 24) check_state();
        end
        for (int k = 0; k < 2; k++) idle(1);
        check_state();

`ifdef VICTIM_BUF_FLUSH_EN
        begin
            laddr_t seen[$];
            int done_cnt, lk_cnt, rdy_cnt, cyc;
            done_cnt = 0; lk_cnt = 0; rdy_cnt = 0; cyc = 0;
            do_reset();
            ins(27'h50, 1, 1); ins(27'h51, 0, 1); ins(27'h52, 1, 1); ins(27'h53, 0, 1);
            bus.flush_req = 1; bus.wb_ready = 1;
            @(posedge clk); #1;
            bus.flush_req = 0; bus.lk_valid = 1; bus.lk_laddr = 27'h51;
            while (done_cnt == 0 && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (bus.flush_done) done_cnt++;
                else begin
                    if (bus.wb_valid && bus.wb_ready) seen.push_back(bus.wb_laddr);
                    if (bus.lk_hit) lk_cnt++;
                    if (bus.ins_ready) rdy_cnt++;
                end
            end
            @(posedge clk); #1;
            chk("flush_done_seen", done_cnt, 1);
            chk("flush_wb_count", seen.size(), 2);
            if (seen.size() == 2) begin
                chk("flush_wb0", seen[0], 27'h50);
                chk("flush_wb1", seen[1], 27'h52);
            end
            chk("flush_lk_hit", lk_cnt, 0);
            chk("flush_ins_ready", rdy_cnt, 0);
            chk("flush_done_pulse", bus.flush_done, 0);
            bus.lk_valid = 0;
            model_reset();
            idle(1);
            check_state();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
